// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM states and the op classification helper used by the unit and the decoder.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_multicycle(input op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Combinational quotient/remainder for div/divu, flagging a zero divisor so
// the caller can leave HI/LO untouched.
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] safe_b;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;

    assign neg_a    = is_signed & dividend[WIDTH-1];
    assign neg_b    = is_signed & divisor[WIDTH-1];
    assign abs_a    = neg_a ? (~dividend + 1'b1) : dividend;
    assign abs_b    = neg_b ? (~divisor + 1'b1) : divisor;
    assign div_zero = (divisor == '0);

    // A dummy divisor of 1 keeps the divider well-defined; the result is discarded.
    assign safe_b = div_zero ? WIDTH'(1) : abs_b;
    assign uq     = abs_a / safe_b;
    assign ur     = abs_a % safe_b;

    // MIN / -1 falls out naturally: |MIN| is 2^(WIDTH-1), negating it wraps back to MIN.
    assign quotient  = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
    assign remainder = neg_a ? (~ur + 1'b1) : ur;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the EX stage: one op per start pulse, fixed
// multi-cycle latency reported on busy, results committed when busy falls.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;

    op_t                op_in;
    logic               accept;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] op_result;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic               div_zero;

    assign op_in  = op_t'(op);
    assign accept = start & ~cancel & ~busy_q & (op_in != OP_NONE);
    assign acc    = {hi_q, lo_q};

    // Sign/zero-extend to 2*WIDTH so the truncated product is exact in both modes.
    assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    muldiv_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .dividend  (src_a),
        .divisor   (src_b),
        .is_signed (op_in == OP_DIV),
        .quotient  (div_q),
        .remainder (div_r),
        .div_zero  (div_zero)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        op_result = acc;
        case (op_in)
            OP_MULT:           op_result = prod_s;
            OP_MULTU:          op_result = prod_u;
            OP_MADD:           op_result = acc + prod_s;
            OP_MADDU:          op_result = acc + prod_u;
            OP_MSUB:           op_result = acc - prod_s;
            OP_MSUBU:          op_result = acc - prod_u;
            OP_DIV, OP_DIVU:   op_result = div_zero ? acc : {div_r, div_q};
            default:           op_result = acc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_in == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (op_in == OP_MTLO) begin
                        lo_d = src_a;
                    end else if (is_multicycle(op_in)) begin
                        pend_d  = op_result;
                        cnt_d   = is_div(op_in) ? DIV_CNT : MULT_CNT;
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_ONE) begin
                    {hi_d, lo_d} = pend_q;
                    busy_d       = 1'b0;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a table of directed vectors plus
// hand-written sequences for back-to-back, cancel and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH    = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [3:0]        op_sig;
    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic              cancel;
    logic              busy;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    muldiv_unit #(
        .WIDTH    (WIDTH),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op_sig),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input op_t o, input logic [31:0] a, b, ph, pl, eh, el,
                                input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b;
        v.pre_hi = ph; v.pre_lo = pl;
        v.exp_hi = eh; v.exp_lo = el;
        v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        start  = 1'b1;
        op_sig = o;
        src_a  = a;
        src_b  = b;
        cancel = c;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        op_sig = OP_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        issue(OP_MTHI, h, 32'h0, 1'b0);
        issue(OP_MTLO, l, 32'h0, 1'b0);
    endtask

    initial begin
        int n;

        vecs[0]  = mk(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB, MULT_LAT);
        vecs[1]  = mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, MULT_LAT);
        vecs[2]  = mk(OP_MADDU, 32'hFFFFFFFF, 32'd2,        32'h12345678, 32'h0,        32'h12345679, 32'hFFFFFFFE, MULT_LAT);
        vecs[3]  = mk(OP_MADD,  32'hFFFFFFFD, 32'd2,        32'h0,        32'd10,       32'h0,        32'd4,        MULT_LAT);
        vecs[4]  = mk(OP_MSUB,  32'd2,        32'd3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, MULT_LAT);
        vecs[5]  = mk(OP_MSUBU, 32'd1,        32'd1,        32'd1,        32'h0,        32'h0,        32'hFFFFFFFF, MULT_LAT);
        vecs[6]  = mk(OP_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        32'd2,        32'd14,       DIV_LAT);
        vecs[7]  = mk(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
        vecs[8]  = mk(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'd1,        32'hFFFFFFFD, DIV_LAT);
        vecs[9]  = mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,        32'h6,        32'h0,        32'h80000000, DIV_LAT);
        vecs[10] = mk(OP_DIV,   32'd9,        32'h0,        32'hAA55AA55, 32'hAA55AA55, 32'hAA55AA55, 32'hAA55AA55, DIV_LAT);
        vecs[11] = mk(OP_DIVU,  32'd9,        32'h0,        32'h1234,     32'h5678,     32'h1234,     32'h5678,     DIV_LAT);
        vecs[12] = mk(OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0,        32'h0,        32'hF,        32'h0FFFFFFF, DIV_LAT);
        vecs[13] = mk(OP_MADD,  32'd1,        32'd1,        32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0,        MULT_LAT);
        vecs[14] = mk(OP_MULT,  32'h80000000, 32'h80000000, 32'h1,        32'h1,        32'h40000000, 32'h0,        MULT_LAT);

        reset  = 1'b0;
        start  = 1'b0;
        op_sig = OP_NONE;
        src_a  = '0;
        src_b  = '0;
        cancel = 1'b0;
        #12;
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset hilo", {hi, lo}, 64'h0);
        reset = 1'b1;
        tick();

        // Table-driven vectors: preload via MTHI/MTLO, run op, check hold, latency, result.
        for (int i = 0; i < 15; i++) begin
            preload(vecs[i].pre_hi, vecs[i].pre_lo);
            check($sformatf("vec%0d preload", i), {hi, lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            check($sformatf("vec%0d hold", i), {busy, hi, lo}, {1'b1, vecs[i].pre_hi, vecs[i].pre_lo});
            wait_idle(n);
            check($sformatf("vec%0d latency", i), 64'(n), 64'(vecs[i].lat));
            check($sformatf("vec%0d result", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Back-to-back with start held: second op accepted only after busy falls.
        preload(32'h0, 32'h0);
        start  = 1'b1;
        op_sig = OP_DIVU;
        src_a  = 32'd100;
        src_b  = 32'd7;
        tick();
        op_sig = OP_DIV;
        src_a  = 32'hFFFFFFF9;
        src_b  = 32'd2;
        wait_idle(n);
        check("b2b first latency", 64'(n), 64'(DIV_LAT));
        check("b2b first result", {hi, lo}, {32'd2, 32'd14});
        tick();
        start  = 1'b0;
        op_sig = OP_NONE;
        check("b2b second accepted", {63'h0, busy}, 64'h1);
        wait_idle(n);
        check("b2b second latency", 64'(n), 64'(DIV_LAT));
        check("b2b second result", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});

        // Cancel blocks a same-cycle start but not an op already in flight.
        preload(32'h11111111, 32'h22222222);
        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        check("cancel mult busy", {63'h0, busy}, 64'h0);
        tick();
        check("cancel mult hilo", {hi, lo}, {32'h11111111, 32'h22222222});
        issue(OP_MTLO, 32'd5, 32'h0, 1'b1);
        check("cancel mtlo lo", {32'h0, lo}, {32'h0, 32'h22222222});
        issue(OP_MULT, 32'd6, 32'd7, 1'b0);
        cancel = 1'b1;
        wait_idle(n);
        cancel = 1'b0;
        check("inflight cancel latency", 64'(n), 64'(MULT_LAT));
        check("inflight cancel result", {hi, lo}, {32'h0, 32'd42});

        // Asynchronous reset during cycle 2 of a divide.
        preload(32'hDEADBEEF, 32'hCAFEF00D);
        issue(OP_DIV, 32'd100, 32'd3, 1'b0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("midop reset busy", {63'h0, busy}, 64'h0);
        check("midop reset hilo", {hi, lo}, 64'h0);
        #2;
        reset = 1'b1;
        tick();
        check("post reset idle", {63'h0, busy}, 64'h0);
        issue(OP_MULT, 32'd3, 32'd4, 1'b0);
        wait_idle(n);
        check("post reset latency", 64'(n), 64'(MULT_LAT));
        check("post reset result", {hi, lo}, {32'h0, 32'd12});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
